// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP raster-scan sequencer and its 3x3 window register.
// Latency: none (types, constants and a pure helper function).
// Backpressure: not applicable.
package lbp_pkg;

   localparam int IMG_DIM = 128;
   localparam int ADDR_W  = 14;
   localparam logic [6:0] XY_MIN = 7'd1;
   localparam logic [6:0] XY_MAX = 7'd126;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL    = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Neighbour byte positions inside the packed 64-bit neighbour word, named by compass direction.
   localparam int NB_NW = 0;  // (-1,-1)
   localparam int NB_N  = 1;  // (-1, 0)
   localparam int NB_NE = 2;  // (-1,+1)
   localparam int NB_W  = 3;  // ( 0,-1)
   localparam int NB_E  = 4;  // ( 0,+1)
   localparam int NB_SW = 5;  // (+1,-1)
   localparam int NB_S  = 6;  // (+1, 0)
   localparam int NB_SE = 7;  // (+1,+1)

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } cell_t;

   // Column-major walk of the 3x3 window: index 0..8 -> (row, col).
   function automatic cell_t fill_cell(input logic [3:0] idx);
      cell_t c;
      c.col = 2'(idx / 4'd3);
      c.row = 2'(idx % 4'd3);
      return c;
   endfunction

endpackage

// File: rtl/lbp_window_reg.sv
// 3x3 pixel window: single-cell load from the ROM, or shift every row one column left.
// Latency: one cycle from load/shift to the outputs.
// Backpressure: none; the controller only loads or shifts when it owns the window.
// Ports: shift_left (col0<=col1, col1<=col2), load_en/load_row/load_col/din (write one cell),
//        center (cell [1][1]), nbr (8 neighbours, byte k = neighbour k).
module lbp_window_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        shift_left,
   input  logic        load_en,
   input  logic [1:0]  load_row,
   input  logic [1:0]  load_col,
   input  logic [7:0]  din,
   output logic [7:0]  center,
   output logic [63:0] nbr
);
   import lbp_pkg::*;

   logic [7:0] win [0:2][0:2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= 8'h00;
            end
         end
      end else if (shift_left) begin
         // Right column becomes stale; it is refetched before the window is presented again.
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
      end else if (load_en) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               if (load_row == 2'(r) && load_col == 2'(c)) begin
                  win[r][c] <= din;
               end
            end
         end
      end
   end

   assign center = win[1][1];

   always_comb begin
      nbr = '0;
      nbr[NB_NW*8 +: 8] = win[0][0];
      nbr[NB_N *8 +: 8] = win[0][1];
      nbr[NB_NE*8 +: 8] = win[0][2];
      nbr[NB_W *8 +: 8] = win[1][0];
      nbr[NB_E *8 +: 8] = win[1][2];
      nbr[NB_SW*8 +: 8] = win[2][0];
      nbr[NB_S *8 +: 8] = win[2][1];
      nbr[NB_SE*8 +: 8] = win[2][2];
   end

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Raster-scan sequencer: fetches 3x3 windows from the gray ROM (9 at row start, 3 per step) and presents them.
// Latency: row-start window 9 fetches + 1 present cycle; following windows 3 + 1 cycles.
// Backpressure: window held stable in PRESENT with no ROM fetches until win_ready; inputs ignored elsewhere.
// Ports: gray_ready/gray_req/gray_addr/gray_data to the ROM; win_valid/win_ready/win_addr/win_center/win_nbr
//        to the threshold stage; finish high from scan completion until reset.
module lbp_scan_ctrl #(
   parameter int DIM_LOG2 = 7,
   parameter int ADDR_W   = 2*DIM_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gray_ready,
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   input  logic [7:0]        gray_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [ADDR_W-1:0] win_addr,
   output logic [7:0]        win_center,
   output logic [63:0]       win_nbr,
   output logic              finish
);
   import lbp_pkg::*;

   localparam logic [DIM_LOG2-1:0] C_FIRST = DIM_LOG2'(XY_MIN);
   localparam logic [DIM_LOG2-1:0] C_LAST  = DIM_LOG2'(XY_MAX);

   state_t              state, state_nxt;
   logic [3:0]          cnt, cnt_nxt;
   logic [DIM_LOG2-1:0] x, y, x_nxt, y_nxt;
   logic                shift_win;
   logic [1:0]          off_r, off_c;
   cell_t               fcell;
   logic [DIM_LOG2-1:0] fetch_row, fetch_col;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
         x     <= C_FIRST;
         y     <= C_FIRST;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         x     <= x_nxt;
         y     <= y_nxt;
      end
   end

   assign fcell = fill_cell(cnt);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      x_nxt     = x;
      y_nxt     = y;
      gray_req  = 1'b0;
      win_valid = 1'b0;
      finish    = 1'b0;
      shift_win = 1'b0;
      off_r     = 2'd0;
      off_c     = 2'd0;
      case (state)
         ST_IDLE: begin
            if (gray_ready) begin
               state_nxt = ST_FILL;
               cnt_nxt   = 4'd0;
            end
         end
         ST_FILL: begin
            gray_req = 1'b1;
            off_r    = fcell.row;
            off_c    = fcell.col;
            if (cnt == 4'd8) begin
               state_nxt = ST_PRESENT;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         ST_SHIFT: begin
            // Only the new right column (x+1) is fetched; the other two were shifted in.
            gray_req = 1'b1;
            off_r    = cnt[1:0];
            off_c    = 2'd2;
            if (cnt == 4'd2) begin
               state_nxt = ST_PRESENT;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         ST_PRESENT: begin
            win_valid = 1'b1;
            if (win_ready) begin
               cnt_nxt = 4'd0;
               if (y == C_LAST && x == C_LAST) begin
                  state_nxt = ST_DONE;
               end else if (x == C_LAST) begin
                  x_nxt     = C_FIRST;
                  y_nxt     = y + 1'b1;
                  state_nxt = ST_FILL;
               end else begin
                  x_nxt     = x + 1'b1;
                  shift_win = 1'b1;
                  state_nxt = ST_SHIFT;
               end
            end
         end
         ST_DONE: begin
            finish = 1'b1;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Offsets 0..2 map to -1..+1 around the center; x,y stay in 1..126 so this never wraps.
   assign fetch_row = y + DIM_LOG2'(off_r) - 1'b1;
   assign fetch_col = x + DIM_LOG2'(off_c) - 1'b1;
   assign gray_addr = gray_req ? {fetch_row, fetch_col} : '0;
   assign win_addr  = {y, x};

   lbp_window_reg u_win (
      .clk        (clk),
      .reset      (reset),
      .shift_left (shift_win),
      .load_en    (gray_req),
      .load_row   (off_r),
      .load_col   (off_c),
      .din        (gray_data),
      .center     (win_center),
      .nbr        (win_nbr)
   );

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
module tb_lbp_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        gray_ready;
   logic        gray_req;
   logic [13:0] gray_addr;
   logic [7:0]  gray_data;
   logic        win_valid;
   logic        win_ready;
   logic [13:0] win_addr;
   logic [7:0]  win_center;
   logic [63:0] win_nbr;
   logic        finish;

   bit rom_mode = 1'b0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lbp_scan_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .gray_ready (gray_ready),
      .gray_req   (gray_req),
      .gray_addr  (gray_addr),
      .gray_data  (gray_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_addr   (win_addr),
      .win_center (win_center),
      .win_nbr    (win_nbr),
      .finish     (finish)
   );

   // ROM image: mode 0 is gray[a]=a[7:0]; mode 1 folds the row in so rows y-1 and y+1 differ.
   function automatic logic [7:0] pix(input logic [13:0] a, input bit m);
      return m ? (a[7:0] ^ {1'b0, a[13:7]}) : a[7:0];
   endfunction

   always_comb gray_data = pix(gray_addr, rom_mode);

   function automatic logic [13:0] a_of(input int r, input int c);
      return {7'(r), 7'(c)};
   endfunction

   function automatic logic [63:0] exp_nbr(input int y, input int x, input bit m);
      int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
      int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 8; k++) v[k*8 +: 8] = pix(a_of(y + dy[k], x + dx[k]), m);
      return v;
   endfunction

   // i-th fetch needed before window (y,x): full column-major 3x3 at row start, else column x+1.
   function automatic logic [13:0] exp_fetch(input int y, input int x, input int i);
      if (x == 1) return a_of(y - 1 + i % 3, x - 1 + i / 3);
      return a_of(y - 1 + i, x + 1);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gray_req"},   gray_req,   0);
      chk({tag, "_gray_addr"},  gray_addr,  0);
      chk({tag, "_win_valid"},  win_valid,  0);
      chk({tag, "_win_addr"},   win_addr,   14'h0081);
      chk({tag, "_win_center"}, win_center, 0);
      chk({tag, "_win_nbr"},    win_nbr,    0);
      chk({tag, "_finish"},     finish,     0);
   endtask

   // Scan model: expected window position, fetches seen for it, handshakes, completion.
   int          my, mx, mfi, hs_cnt, cyc, first_req_cyc, fin_cyc;
   bit          mdone, seen_req, seen_fin;
   logic [13:0] last_hs;

   always @(negedge clk) begin
      #1;
      cyc++;
      if (!reset) begin
         my = 1; mx = 1; mfi = 0; hs_cnt = 0;
         mdone = 0; seen_req = 0; seen_fin = 0;
      end else begin
         chk("finish_level", finish, mdone);
         if (finish && !seen_fin) begin
            seen_fin = 1;
            fin_cyc  = cyc;
         end
         if (gray_req) begin
            if (!seen_req) begin
               seen_req      = 1;
               first_req_cyc = cyc;
            end
            chk("req_with_valid", win_valid, 0);
            if (mdone || mfi >= ((mx == 1) ? 9 : 3)) chk("fetch_extra", gray_req, 0);
            else begin
               chk("fetch_addr", gray_addr, exp_fetch(my, mx, mfi));
               mfi++;
            end
         end else begin
            chk("addr_no_req", gray_addr, 0);
         end
         if (win_valid) begin
            if (mdone) chk("valid_after_done", win_valid, 0);
            else begin
               chk("fetches_per_win", mfi, (mx == 1) ? 9 : 3);
               chk("win_addr", win_addr, a_of(my, mx));
               chk("win_center", win_center, pix(a_of(my, mx), rom_mode));
               chk("win_nbr", win_nbr, exp_nbr(my, mx, rom_mode));
               if (win_ready) begin
                  hs_cnt++;
                  last_hs = win_addr;
                  mfi     = 0;
                  if (mx == 126) begin
                     if (my == 126) mdone = 1;
                     else begin
                        mx = 1;
                        my++;
                     end
                  end else mx++;
               end
            end
         end
      end
   end

   logic [13:0] fill0 [0:8] = '{14'h0000, 14'h0080, 14'h0100, 14'h0001, 14'h0081,
                                14'h0101, 14'h0002, 14'h0082, 14'h0102};
   logic [13:0] shift1 [0:2] = '{14'h0003, 14'h0083, 14'h0103};
   logic [63:0] nbr_first = 64'h0201008280020100;
   bit found;

   initial begin
      reset      = 1'b0;
      gray_ready = 1'b0;
      win_ready  = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");

      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("idle_wait_req", gray_req, 0);
      end

      // First window: 9 column-major fetches, then presentation.
      gray_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("first_fill_req", gray_req, 1);
         chk("first_fill_addr", gray_addr, fill0[i]);
      end
      gray_ready = 1'b0;
      @(negedge clk);
      chk("first_win_valid", win_valid, 1);
      chk("first_win_addr", win_addr, 14'h0081);
      chk("first_win_center", win_center, 8'h81);
      chk("first_win_nbr", win_nbr, nbr_first);

      // Backpressure: window held, no fetches.
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", win_valid, 1);
         chk("bp_addr", win_addr, 14'h0081);
         chk("bp_center", win_center, 8'h81);
         chk("bp_nbr", win_nbr, nbr_first);
         chk("bp_no_req", gray_req, 0);
      end

      // Column reuse: only the new right column is fetched.
      win_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reuse_req", gray_req, 1);
         chk("reuse_addr", gray_addr, shift1[i]);
         @(negedge clk);
      end
      chk("reuse_valid", win_valid, 1);
      chk("reuse_win_addr", win_addr, 14'h0082);
      chk("reuse_center", win_center, 8'h82);
      chk("reuse_nbr_e", win_nbr[39:32], 8'h83);

      // Row wrap after the last window of row 1.
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk);
         if (win_valid && win_addr == 14'h00FE) found = 1;
      end
      chk("row_end_seen", win_addr, 14'h00FE);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("wrap_fill_req", gray_req, 1);
         if (i == 0) chk("wrap_fill_addr0", gray_addr, 14'h0080);
      end
      @(negedge clk);
      chk("wrap_win_valid", win_valid, 1);
      chk("wrap_win_addr", win_addr, 14'h0101);

      // Mid-scan reset during the first SHIFT cycle of row 2.
      @(negedge clk);
      chk("shift_req", gray_req, 1);
      chk("shift_addr", gray_addr, 14'h0083);
      reset = 1'b0;
      #1;
      chk_reset_vals("async_reset");
      rom_mode = 1'b1;
      @(negedge clk);
      reset      = 1'b1;
      gray_ready = 1'b1;
      @(negedge clk);
      chk("restart_req", gray_req, 1);
      chk("restart_addr", gray_addr, 14'h0000);
      gray_ready = 1'b0;

      // Full scan with win_ready held high.
      found = 0;
      for (int i = 0; i < 70000 && !found; i++) begin
         @(negedge clk);
         if (finish) found = 1;
      end
      chk("finish_reached", finish, 1);
      @(negedge clk);
      chk("handshakes", hs_cnt, 15876);
      chk("last_win_addr", last_hs, 14'h3F7E);
      chk("scan_cycles", fin_cyc - first_req_cyc, 64260);
      repeat (10) begin
         @(negedge clk);
         chk("done_finish", finish, 1);
         chk("done_no_req", gray_req, 0);
         chk("done_no_valid", win_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lbp_scan_ctrl.md
Name: lbp_scan_ctrl

Overview:
- Raster-scan sequencer for the LBP datapath over a 128x128 gray image held in the gray ROM.
- Reuses 3x3 window columns: a full 9-pixel fetch at each row start, then only the 3 new right-column pixels per step.
- Presents each complete window (center plus 8 neighbours and pixel address) to the downstream threshold stage through a valid/ready handshake.
- Sits between the gray ROM interface and the threshold/LBP-RAM write stage, replacing 9-fetch-per-pixel sequencing.

Parameters:
- DIM_LOG2, 7, log2 of image side (image is 2^DIM_LOG2 square).
- ADDR_W, 14, gray/window address width; fixed to 2*DIM_LOG2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- gray_ready  in  1  ROM contents available; sampled only in IDLE.
- gray_req  out  1  fetch strobe; high on every fetch cycle.
- gray_addr  out  ADDR_W  fetch address {row, col}, row in the MSBs.
- gray_data  in  8  pixel for gray_addr, valid in the same cycle (asynchronous ROM).
- win_valid  out  1  window presented.
- win_ready  in  1  downstream accepts the window.
- win_addr  out  ADDR_W  {y, x} of the window center.
- win_center  out  8  center pixel.
- win_nbr  out  64  neighbours, byte k = offset k: 0(-1,-1) 1(-1,0) 2(-1,+1) 3(0,-1) 4(0,+1) 5(+1,-1) 6(+1,0) 7(+1,+1), given as (dy,dx).
- finish  out  1  scan complete.

Behaviour:
- Reset (reset=0, async) returns the block to IDLE. Output reset values: gray_req=0, gray_addr=0, win_valid=0, win_addr=14'h0081 (y=1, x=1), win_center=0, win_nbr=0, finish=0. All window registers clear.
- Reset asserted mid-operation aborts the scan. After release, the block waits in IDLE for gray_ready again.
- States: IDLE, FILL, SHIFT, PRESENT, DONE.
- IDLE: go to FILL when gray_ready=1.
- FILL: runs 9 cycles (fill count 0..8). Fetch order is column-major: cols x-1, x, x+1; within each column rows y-1, y, y+1. gray_data loads window cell [row][col]. After the 9th fetch, go to PRESENT.
- SHIFT: runs 3 cycles. Window columns were shifted left on entry. Fetches column x+1, rows y-1, y, y+1, into the right column. Then go to PRESENT.
- PRESENT:
  - win_valid=1; win_addr, win_center and win_nbr are driven from the window registers and stay stable until the handshake.
  - No gray_req while in PRESENT.
  - On win_valid and win_ready:
    - y=126 and x=126: go to DONE.
    - else x=126: x<=1, y<=y+1, go to FILL.
    - else: x<=x+1, shift the window left, go to SHIFT.
- DONE: finish=1, held until reset. No further requests.
- gray_req=1 exactly in FILL and SHIFT. gray_addr=0 in all other states.
- Coordinates: x and y range 1..126. Neighbour arithmetic is 7-bit and never wraps inside the legal range.
- Latency with win_ready held at 1:
  - row-start window: 9 fetch cycles + 1 PRESENT cycle;
  - subsequent windows: 3 + 1 cycles;
  - whole image: 126 x (10 + 125 x 4) = 64260 cycles from first gray_req to the DONE entry cycle.
- win_ready is ignored outside PRESENT. gray_ready is ignored outside IDLE.

Decomposition:
- Shared package lbp_pkg holds:
  - IMG_DIM=128, ADDR_W=14, XY_MIN=1, XY_MAX=126;
  - state encoding constants (IDLE, FILL, SHIFT, PRESENT, DONE);
  - neighbour index constants 0..7.
- One sub-module, lbp_window_reg: a 3x3 8-bit register array. Ports: shift_left, load_en, load_row, load_col, din. Outputs: center and the packed 64-bit neighbours.
- The FSM, x/y counters and fetch counter stay in lbp_scan_ctrl.

Test Plan:
- First window:
  - Stimulus: release reset, then gray_ready=1; ROM loaded with gray[a]=a[7:0].
  - Required: gray_addr sequence 0x0000, 0x0080, 0x0100, 0x0001, 0x0081, 0x0101, 0x0002, 0x0082, 0x0102, then win_valid with win_addr=0x0081, win_center=0x81, win_nbr bytes {0x00, 0x01, 0x02, 0x80, 0x82, 0x00, 0x01, 0x02}.
- Column reuse:
  - Stimulus: accept the first window.
  - Required: exactly 3 fetches at 0x0003, 0x0083, 0x0103, then win_addr=0x0082 with win_center=0x82 and neighbour byte 4=0x83.
- Row wrap:
  - Stimulus: accept win_addr=0x00FE.
  - Required: FILL restarts at gray_addr=0x0080 with 9 fetches; next win_addr=0x0101.
- Backpressure:
  - Stimulus: hold win_ready=0 for 5 cycles in PRESENT.
  - Required: win_valid stays 1, win_* outputs are unchanged, gray_req=0 throughout.
- Full scan:
  - Stimulus: win_ready=1 constantly.
  - Required: 15876 handshakes; last win_addr=0x3F7E; finish rises 64260 cycles after the first gray_req and stays high.
- Mid-scan reset:
  - Stimulus: assert reset=0 during a SHIFT cycle.
  - Required: outputs return to their reset values immediately (async). After release with gray_ready=1, the scan restarts at address 0x0000.
